// File: rtl/tilemap_writer.sv
// Command-driven writer for the tile-index RAM: single write, rectangle fill, clear all.
// Optional macro TILEMAP_CLIP_EN suppresses writes to off-grid slots.
module tilemap_writer #(
  parameter int unsigned COLS        = 120,
  parameter int unsigned ROWS        = 68,
  parameter logic [5:0]  TRANSPARENT = 6'd63
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [1:0]  i_cmd_op,
  input  logic [6:0]  i_cmd_x,
  input  logic [6:0]  i_cmd_y,
  input  logic [6:0]  i_cmd_w,
  input  logic [6:0]  i_cmd_h,
  input  logic [5:0]  i_cmd_tile,
  output logic        o_wr_en,
  output logic [12:0] o_wr_address,
  output logic [5:0]  o_wr_data,
  output logic        o_busy,
  output logic        o_done
);

  localparam int unsigned AW = 13;
  localparam int unsigned CW = 7;
  localparam int unsigned PW = 8;
  localparam int unsigned TW = 6;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] x0, x0_n, w_r, w_n, col_left, col_left_n, row_left, row_left_n;
  logic [PW-1:0] cx, cx_n, cy, cy_n;
  logic [AW-1:0] row_base, row_base_n, addr_n;
  logic [TW-1:0] tile, tile_n, data_n;
  logic          ready_n, wr_en_n, busy_n, done_n, slot_ok;
  logic [CW-1:0] cmd_x, cmd_y, cmd_w, cmd_h;
  logic [TW-1:0] cmd_tile;
  logic          cmd_null;

  // Per-op field override: single write is 1x1, clear is the full grid in the transparent tile
  always_comb begin
    cmd_x    = i_cmd_x;
    cmd_y    = i_cmd_y;
    cmd_w    = i_cmd_w;
    cmd_h    = i_cmd_h;
    cmd_tile = i_cmd_tile;
    cmd_null = 1'b0;
    case (i_cmd_op)
      2'b00: begin
        cmd_w = CW'(1);
        cmd_h = CW'(1);
      end
      2'b10: begin
        cmd_x    = '0;
        cmd_y    = '0;
        cmd_w    = CW'(COLS);
        cmd_h    = CW'(ROWS);
        cmd_tile = TRANSPARENT;
      end
      2'b11:   cmd_null = 1'b1;
      default: ;
    endcase
    if (cmd_w == '0 || cmd_h == '0) cmd_null = 1'b1;
  end

  // Next state and next register values; outputs are registered from the next-slot values
  always_comb begin
    state_n    = state;
    x0_n       = x0;
    w_n        = w_r;
    tile_n     = tile;
    cx_n       = cx;
    cy_n       = cy;
    row_base_n = row_base;
    col_left_n = col_left;
    row_left_n = row_left;
    ready_n    = 1'b0;
    wr_en_n    = 1'b0;
    busy_n     = o_busy;
    done_n     = 1'b0;
    addr_n     = o_wr_address;
    data_n     = o_wr_data;
    slot_ok    = 1'b1;

    case (state)
      S_IDLE: begin
        ready_n = 1'b1;
        busy_n  = 1'b0;
        if (i_cmd_valid && o_cmd_ready) begin
          ready_n = 1'b0;
          busy_n  = 1'b1;
          if (cmd_null) begin
            state_n = S_DONE;
            done_n  = 1'b1;
          end else begin
            state_n    = S_RUN;
            x0_n       = cmd_x;
            w_n        = cmd_w;
            tile_n     = cmd_tile;
            cx_n       = PW'(cmd_x);
            cy_n       = PW'(cmd_y);
            row_base_n = AW'(32'(cmd_y) * COLS);
            col_left_n = cmd_w;
            row_left_n = cmd_h;
          end
        end
      end
      S_RUN: begin
        busy_n = 1'b1;
        if (col_left == CW'(1)) begin
          if (row_left == CW'(1)) begin
            state_n = S_DONE;
            done_n  = 1'b1;
          end else begin
            cx_n       = PW'(x0);
            cy_n       = cy + PW'(1);
            row_base_n = row_base + AW'(COLS);
            col_left_n = w_r;
            row_left_n = row_left - CW'(1);
          end
        end else begin
          cx_n       = cx + PW'(1);
          col_left_n = col_left - CW'(1);
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        ready_n = 1'b1;
        busy_n  = 1'b0;
      end
      default: state_n = S_IDLE;
    endcase

`ifdef TILEMAP_CLIP_EN
    slot_ok = (cx_n < PW'(COLS)) && (cy_n < PW'(ROWS));
`else
    slot_ok = 1'b1;
`endif

    if (state_n == S_RUN) begin
      wr_en_n = slot_ok;
      addr_n  = row_base_n + AW'(cx_n);
      data_n  = tile_n;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      x0           <= '0;
      w_r          <= '0;
      tile         <= '0;
      cx           <= '0;
      cy           <= '0;
      row_base     <= '0;
      col_left     <= '0;
      row_left     <= '0;
      o_cmd_ready  <= 1'b0;
      o_wr_en      <= 1'b0;
      o_wr_address <= '0;
      o_wr_data    <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      state        <= state_n;
      x0           <= x0_n;
      w_r          <= w_n;
      tile         <= tile_n;
      cx           <= cx_n;
      cy           <= cy_n;
      row_base     <= row_base_n;
      col_left     <= col_left_n;
      row_left     <= row_left_n;
      o_cmd_ready  <= ready_n;
      o_wr_en      <= wr_en_n;
      o_wr_address <= addr_n;
      o_wr_data    <= data_n;
      o_busy       <= busy_n;
      o_done       <= done_n;
    end
  end

endmodule

// File: doc/tilemap_writer.md
# tilemap_writer

Command-driven writer for the 120×68 tile-index (generator) RAM that the layer renderers read. It sits between the game logic and the RAM's write port. It accepts one command at a time: single-tile write, rectangle fill, or full clear. Each command becomes a stream of one RAM write per clock at address `y*120 + x`, with the 6-bit tile index as data. Index 63 (6'b111111) is the transparent tile.

## Interface
Parameters:
- `COLS`, 120: grid width in tiles (480 px / 4).
- `ROWS`, 68: grid height in tiles (272 px / 4).
- `TRANSPARENT`, 6'd63: tile index written by the clear command.

Ports:
- `i_clk`  in  1  system clock; the only clock.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_cmd_valid`  in  1  command present.
- `o_cmd_ready`  out  1  writer idle, able to accept a command.
- `i_cmd_op`  in  2  00 single write, 01 fill rect, 10 clear all, 11 reserved.
- `i_cmd_x`, `i_cmd_y`  in  7 each  top-left tile coordinate.
- `i_cmd_w`, `i_cmd_h`  in  7 each  rectangle size in tiles; op 01 only.
- `i_cmd_tile`  in  6  tile index to write.
- `o_wr_en`  out  1  RAM write strobe.
- `o_wr_address`  out  13  RAM write address.
- `o_wr_data`  out  6  RAM write data.
- `o_busy`  out  1  command in progress.
- `o_done`  out  1  one-cycle pulse after a command's last write slot.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `o_cmd_ready`=1. On `i_cmd_valid & o_cmd_ready`, latch all fields and go to RUN.
  - Op 00: w=h=1.
  - Op 10: x=y=0, w=COLS, h=ROWS, tile=TRANSPARENT.
  - Op 11, or w=0 or h=0: go straight to DONE with no writes.
- RUN: one slot per cycle, row-major.
  - Per slot: present `o_wr_en`=1, address = row_base + cx, data = tile.
  - Advance cx. After w slots in a row, reset cx to x0, add COLS to row_base, increment cy.
  - row_base is a running 13-bit accumulator initialised to y0*COLS. No multiplier in the per-cycle path.
  - Counters: col_left and row_left, 7 bits each. No 8-bit end-coordinate compare.
  - After w*h slots go to DONE.
- DONE: `o_done`=1 for one cycle, `o_wr_en`=0, then IDLE.
- Outputs are registered. `o_wr_en` is low in every cycle outside RUN slots.
- Address arithmetic is modulo 2^13.
- Reset mid-command aborts the command. No further writes are issued. Writes already issued are not undone.

## Timing
- Reset values: `o_cmd_ready`=0 in the reset cycle, 1 from the first cycle after reset. `o_wr_en`=0, `o_wr_address`=0, `o_wr_data`=0, `o_busy`=0, `o_done`=0.
- Accept edge E: `o_cmd_ready` and `o_busy` change at E. The first write slot is valid during the cycle following E.
- A w×h command occupies exactly w*h RUN cycles, clipped or not. `o_done` is high in the cycle after the last slot. `o_cmd_ready` returns the cycle after `o_done`.
- Command-to-next-accept minimum is w*h+2 cycles.
- `o_busy`=1 from accept until `o_done` clears.
- Commands presented while busy are held off: `o_cmd_ready`=0 and fields are not sampled.

## Configuration
- Macro `TILEMAP_CLIP_EN`.
- Defined: a slot whose cx≥COLS or cy≥ROWS (tracked in 8 bits) has `o_wr_en`=0. It still consumes its cycle.
- Undefined: no clipping. Every slot is written at the modulo-2^13 address. Off-grid columns alias into the next row.

## Test plan
- Reset, then op 00 at (5,2), tile 7: one write, addr 245, data 7, in the cycle after accept; `o_done` the next cycle; `o_cmd_ready` the cycle after that.
- `TILEMAP_CLIP_EN`, op 01 at (118,66), w=4, h=3, tile 9: 12 RUN cycles. Writes only to 8038, 8039, 8158, 8159. No other `o_wr_en`.
- Op 10: 8160 consecutive writes of 63, addresses 0 to 8159 ascending, then `o_done`.
- Op 01 with w=0, then op 11: no writes for either. `o_done` one cycle after each accept.
- Hold `i_cmd_valid` with a second fill queued during a 2×2 fill: the second is accepted only after the first's `o_done`. Addresses follow in order with no gap or overlap.
- Assert `i_rst` for one cycle after 5 writes of a 10×10 fill: `o_wr_en` is 0 from the next cycle. Ready returns on the following cycle. No `o_done` pulse.
